mcdf_arbiter_rr: RTL and testbench
==================================

# mcdf_arbiter_rr

Parametrised N-channel packet arbiter between the MCDF slave ports and the formatter. It arbitrates on per-channel priority registers. Priority ties are broken round-robin. The grant is held for a whole packet, and the grant is released only after the programmed number of beats has been acknowledged. Decision, channel id and packet length are registered; the data/valid path is a combinational mux of the granted channel.

## Interface
Parameters:
- NCH, 4, number of slave channels (2..8)
- DW, 32, data width
- PRW, 2, priority field width per channel; value 0 = highest priority
- PLW, 3, packet-length field width per channel (1..4)
- IDW, derived = max(1, clog2(NCH)), id width

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  reset; asynchronous, active-low
- slv_prio_i  in  NCH*PRW  channel priorities; channel k at [k*PRW +: PRW]
- slv_pkglen_i  in  NCH*PLW  packet-length codes; channel k at [k*PLW +: PLW]
- slv_data_i  in  NCH*DW  channel data; channel k at [k*DW +: DW]
- slv_req_i  in  NCH  channel has a packet pending
- slv_val_i  in  NCH  channel data valid
- a2s_ack_o  out  NCH  per-channel ack, one-hot or zero
- f2a_id_req_i  in  1  formatter requests a new arbitration
- f2a_ack_i  in  1  formatter accepts the current beat
- a2f_val_o  out  1  beat valid to formatter
- a2f_id_o  out  IDW  granted channel id
- a2f_data_o  out  DW  granted channel data
- a2f_pkglen_sel_o  out  PLW  latched pkglen code of the granted channel
- a2f_busy_o  out  1  grant active (state GRANT)

## Operation
States:
- IDLE: no grant is held.
  - a2f_val_o = 0, a2f_data_o = 0 and a2s_ack_o = 0.
  - a2f_id_o and a2f_pkglen_sel_o hold the values from the last grant (0 after reset).
- GRANT: channel g is selected.
  - a2f_data_o = data[g] and a2f_val_o = slv_val_i[g].
  - a2s_ack_o[g] = f2a_ack_i; all other ack bits are 0.

Transitions:
- IDLE to GRANT: f2a_id_req_i = 1 and at least one slv_req_i bit set, sampled on the clock edge.
  - Winner: the requesting channel with the numerically lowest priority value.
  - Ties between equal-priority requesters are broken round-robin. The search starts at channel (rr_ptr+1) mod NCH.
  - On grant, the following are registered: g into a2f_id_o; that channel's pkglen code into a2f_pkglen_sel_o; rr_ptr <= g; beat counter <= 0.
- IDLE, no request: f2a_id_req_i = 1 with slv_req_i = 0 leaves the block in IDLE with no register change.
- GRANT to IDLE: the edge on which a beat completes and the beat counter equals beats-1.
- f2a_id_req_i is ignored while in GRANT.

Beat accounting:
- A beat completes on any cycle where a2f_val_o = 1 and f2a_ack_i = 1.
- beats = 1 << pkglen code.
- The counter width is 2**PLW bits, so the maximum count is reached without wrap.
- The counter increments only on a completed beat.

Channel behaviour during a grant:
- slv_req_i[g] dropping mid-packet does not end the grant.
- Priority or pkglen changes during GRANT take effect at the next arbitration only.

## Timing
- Arbitration latency: 1 cycle.
  - f2a_id_req_i is high in cycle T; a2f_busy_o, a2f_id_o and a2f_pkglen_sel_o are valid in T+1.
  - The data mux and ack path are live from T+1.
- The ack path is combinational, with zero latency from f2a_ack_i to a2s_ack_o[g].
- Final beat: the ack in cycle T is forwarded; a2f_busy_o = 0 from T+1.
  - A new grant is possible with f2a_id_req_i high in T+1, giving busy again in T+2.
- Reset values: a2f_val_o 0, a2f_id_o 0, a2f_data_o 0, a2f_pkglen_sel_o 0, a2s_ack_o 0, a2f_busy_o 0, rr_ptr NCH-1, counter 0, state IDLE.
- Reset mid-packet: the grant is dropped immediately and asynchronously, and every output returns to its reset value.

## Configuration
- ARB_RR_EN defined: round-robin tie-break as described above.
- ARB_RR_EN undefined: fixed tie-break, where the lowest channel index wins among equal priorities.
  - rr_ptr is not implemented.
  - All other behaviour is identical.

## Test plan
- Single request: NCH=4, only ch2 requests, prio 1, pkglen 2, f2a_id_req_i pulsed.
  - Cycle+1: busy=1, id=2, pkglen_sel=2.
  - 4 acked beats are forwarded on a2s_ack_o[2] only.
  - Busy drops on the cycle after the 4th ack.
- Strict priority: ch0 prio 2, ch1 prio 3, ch3 prio 0, all requesting.
  - The grant goes to ch3; ch0 and ch1 get no ack during the packet.
- Round-robin tie: ch0, ch1 and ch3 at prio 1, continuous requests, pkglen 0, repeated id_req.
  - Grant order 0,1,3,0,1,3 with ARB_RR_EN defined.
  - Grant order 0,0,0 with ARB_RR_EN undefined.
- Back-pressure and hold:
  - a2f_val_o=1 with f2a_ack_i low for 5 cycles: the counter does not advance.
  - f2a_id_req_i and a higher-priority request arriving mid-packet do not change id.
- Boundaries:
  - pkglen code 7 (PLW=3): exactly 128 beats are needed before busy drops.
  - id_req with slv_req_i=0: the block stays idle.
  - rstn_i asserted at beat 3 of 8: outputs return to reset values immediately, and the next grant starts the beat count from 0.

Source files
------------

// File: rtl/mcdf_arbiter_rr.sv
// mcdf_arbiter_rr: N-channel priority packet arbiter with round-robin tie-break and per-packet grant hold.
//   Optional feature macro: ARB_RR_EN (defined = round-robin tie-break, undefined = lowest index wins ties).
//   clk_i/rstn_i        : clock, asynchronous active-low reset
//   slv_prio_i          : per-channel priority (0 = highest)
//   slv_pkglen_i        : per-channel packet-length code, beats = 1 << code
//   slv_data_i/req/val  : per-channel data, packet pending, data valid
//   a2s_ack_o           : per-channel beat ack (one-hot or zero)
//   f2a_id_req_i/ack_i  : formatter arbitration request, beat accept
//   a2f_val/id/data_o   : granted beat valid, channel id, data
//   a2f_pkglen_sel_o    : latched length code of the granted channel
//   a2f_busy_o          : grant active
module mcdf_arbiter_rr #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int PRW = 2,
    parameter int PLW = 3,
    parameter int IDW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NCH*PRW-1:0] slv_prio_i,
    input  logic [NCH*PLW-1:0] slv_pkglen_i,
    input  logic [NCH*DW-1:0]  slv_data_i,
    input  logic [NCH-1:0]     slv_req_i,
    input  logic [NCH-1:0]     slv_val_i,
    output logic [NCH-1:0]     a2s_ack_o,
    input  logic               f2a_id_req_i,
    input  logic               f2a_ack_i,
    output logic               a2f_val_o,
    output logic [IDW-1:0]     a2f_id_o,
    output logic [DW-1:0]      a2f_data_o,
    output logic [PLW-1:0]     a2f_pkglen_sel_o,
    output logic               a2f_busy_o
);
    // Wide enough to hold beats-1 for the largest length code without wrapping.
    localparam int CW = 2**PLW;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] id_q, win;
    logic [PLW-1:0] len_q;
    logic [CW-1:0]  cnt_q;
    logic [PRW-1:0] best;
    logic           win_vld, grant, beat, last;
    int             c;
`ifdef ARB_RR_EN
    logic [IDW-1:0] rr_q;
`endif

    // Scan channels in tie-break order; only a strictly better priority displaces
    // the current candidate, so the first requester in scan order wins a tie.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        best    = '1;
        c       = 0;
        for (int i = 0; i < NCH; i++) begin
`ifdef ARB_RR_EN
            c = int'(rr_q) + 1 + i;
            if (c >= NCH) c = c - NCH;
`else
            c = i;
`endif
            if (slv_req_i[c] && (!win_vld || slv_prio_i[c*PRW +: PRW] < best)) begin
                win_vld = 1'b1;
                best    = slv_prio_i[c*PRW +: PRW];
                win     = IDW'(c);
            end
        end
    end

    assign grant = (state_q == IDLE) && f2a_id_req_i && win_vld;
    assign beat  = a2f_val_o && f2a_ack_i;
    assign last  = cnt_q == ((CW'(1) << len_q) - CW'(1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = grant ? GRANT : IDLE;
        else                 state_d = (beat && last) ? IDLE : GRANT;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            id_q  <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else if (grant) begin
            id_q  <= win;
            len_q <= slv_pkglen_i[int'(win)*PLW +: PLW];
            cnt_q <= '0;
        end else if (beat) begin
            cnt_q <= last ? '0 : cnt_q + CW'(1);
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)    rr_q <= IDW'(NCH-1);
        else if (grant) rr_q <= win;
    end
`endif

    always_comb begin
        a2f_busy_o       = state_q == GRANT;
        a2f_id_o         = id_q;
        a2f_pkglen_sel_o = len_q;
        a2f_val_o        = a2f_busy_o ? slv_val_i[id_q] : 1'b0;
        a2f_data_o       = a2f_busy_o ? slv_data_i[int'(id_q)*DW +: DW] : '0;
        a2s_ack_o        = (a2f_busy_o && f2a_ack_i) ? (NCH'(1) << id_q) : '0;
    end
endmodule

// File: tb/tb_mcdf_arbiter_rr.sv
// tb_mcdf_arbiter_rr: directed and randomized checks of mcdf_arbiter_rr against a packet-level reference model.
module tb_mcdf_arbiter_rr;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int PRW = 2;
    localparam int PLW = 3;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rstn_i;
    logic [NCH*PRW-1:0] prio;
    logic [NCH*PLW-1:0] plen;
    logic [NCH*DW-1:0]  data;
    logic [NCH-1:0]     req, val, ack_o;
    logic               id_req, ack;
    logic               a2f_val, busy;
    logic [IDW-1:0]     id;
    logic [DW-1:0]      a2f_data;
    logic [PLW-1:0]     plsel;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: packet-level view of the arbiter
    bit m_busy;
    int m_id, m_len, m_cnt, m_rr;

    always #5 clk = ~clk;

    mcdf_arbiter_rr #(.NCH(NCH), .DW(DW), .PRW(PRW), .PLW(PLW)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .slv_prio_i(prio), .slv_pkglen_i(plen),
        .slv_data_i(data), .slv_req_i(req), .slv_val_i(val), .a2s_ack_o(ack_o),
        .f2a_id_req_i(id_req), .f2a_ack_i(ack), .a2f_val_o(a2f_val), .a2f_id_o(id),
        .a2f_data_o(a2f_data), .a2f_pkglen_sel_o(plsel), .a2f_busy_o(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pr(int k);
        return int'(prio[k*PRW +: PRW]);
    endfunction

    // Winner = lowest priority value; ties go to the candidate closest after the last grant
    // (round-robin) or to the lowest index (fixed).
    function automatic int pick();
        int minp = 1 << PRW;
        int bd = 2 * NCH;
        int w = -1;
        int d;
        for (int k = 0; k < NCH; k++)
            if (req[k] && pr(k) < minp) minp = pr(k);
        for (int k = 0; k < NCH; k++) begin
            if (req[k] && pr(k) == minp) begin
`ifdef ARB_RR_EN
                d = (k - m_rr - 1 + 2 * NCH) % NCH;
`else
                d = k;
`endif
                if (d < bd) begin
                    bd = d;
                    w = k;
                end
            end
        end
        return w;
    endfunction

    task automatic check_outs();
        check("busy", 64'(busy), 64'(m_busy));
        check("id", 64'(id), 64'(m_id));
        check("pkglen_sel", 64'(plsel), 64'(m_len));
        check("val", 64'(a2f_val), m_busy ? 64'(val[m_id]) : 64'd0);
        check("data", 64'(a2f_data), m_busy ? 64'(data[m_id*DW +: DW]) : 64'd0);
        check("ack", 64'(ack_o), (m_busy && ack) ? 64'(1) << m_id : 64'd0);
    endtask

    // One clock: fresh data, compare outputs mid-cycle, advance model across the edge.
    task automatic tick();
        int w;
        bit nb;
        int nid, nlen, ncnt, nrr;
        for (int k = 0; k < NCH; k++) data[k*DW +: DW] = $urandom;
        #2;
        check_outs();
        nb = m_busy; nid = m_id; nlen = m_len; ncnt = m_cnt; nrr = m_rr;
        if (!m_busy) begin
            w = pick();
            if (id_req && w >= 0) begin
                nb = 1; nid = w; nlen = int'(plen[w*PLW +: PLW]); ncnt = 0; nrr = w;
            end
        end else if (val[m_id] && ack) begin
            if (m_cnt == (1 << m_len) - 1) nb = 0;
            else ncnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_id = nid; m_len = nlen; m_cnt = ncnt; m_rr = nrr;
    endtask

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_len = 0; m_cnt = 0; m_rr = NCH - 1;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        #2;
        model_reset();
        check_outs();
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic set_ch(input int k, input int p, input int l);
        prio[k*PRW +: PRW] = PRW'(p);
        plen[k*PLW +: PLW] = PLW'(l);
    endtask

    // Ack until the model says the packet ended, bounded.
    task automatic drain();
        int n = 0;
        ack = 1'b1;
        while (m_busy && n < 300) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(m_busy), 64'd0);
    endtask

    int exp_rr[6];

    initial begin
        rstn_i = 1'b0; prio = '1; plen = '0; data = '0; req = '0; val = '0; id_req = 1'b0; ack = 1'b0;
        model_reset();
        do_reset();

        // Single request: ch2, prio 1, 4 beats
        set_ch(2, 1, 2);
        req = 4'b0100; val = 4'b0100; id_req = 1'b1;
        tick();
        id_req = 1'b0;
        check("single_busy", 64'(busy), 64'd1);
        check("single_id", 64'(id), 64'd2);
        check("single_plsel", 64'(plsel), 64'd2);
        ack = 1'b1;
        repeat (3) tick();
        check("single_busy_b3", 64'(busy), 64'd1);
        tick();
        check("single_busy_end", 64'(busy), 64'd0);
        ack = 1'b0; req = '0;

        // Strict priority: ch3 (prio 0) beats ch0 (2) and ch1 (3)
        set_ch(0, 2, 1); set_ch(1, 3, 1); set_ch(3, 0, 1);
        req = 4'b1011; val = 4'b1111; id_req = 1'b1;
        tick();
        id_req = 1'b0;
        check("strict_id", 64'(id), 64'd3);
        drain();

        // Tie among ch0, ch1, ch3 at prio 1, single-beat packets
        do_reset();
`ifdef ARB_RR_EN
        exp_rr = '{0, 1, 3, 0, 1, 3};
`else
        exp_rr = '{0, 0, 0, 0, 0, 0};
`endif
        set_ch(0, 1, 0); set_ch(1, 1, 0); set_ch(2, 0, 0); set_ch(3, 1, 0);
        req = 4'b1011; val = 4'b1111; ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            id_req = 1'b1;
            tick();
            id_req = 1'b0;
            check($sformatf("rr_order%0d", i), 64'(id), 64'(exp_rr[i]));
            tick();
        end

        // Back-pressure and hold: ch1, 4 beats
        ack = 1'b0; req = 4'b0010; set_ch(1, 2, 2);
        id_req = 1'b1;
        tick();
        id_req = 1'b0;
        repeat (5) tick();
        ack = 1'b1;
        tick();
        id_req = 1'b1; req = 4'b1111; set_ch(0, 0, 0);
        tick();
        check("hold_id", 64'(id), 64'd1);
        id_req = 1'b0;
        repeat (2) tick();
        check("hold_busy", 64'(busy), 64'd0);
        ack = 1'b0;

        // Longest packet: code 7 = 128 beats
        set_ch(0, 0, 7); req = 4'b0001; val = 4'b0001; id_req = 1'b1;
        tick();
        id_req = 1'b0; ack = 1'b1;
        repeat (127) tick();
        check("len7_busy127", 64'(busy), 64'd1);
        tick();
        check("len7_busy128", 64'(busy), 64'd0);
        ack = 1'b0;

        // Arbitration request with nothing pending
        req = '0; id_req = 1'b1;
        repeat (3) tick();
        check("noreq_busy", 64'(busy), 64'd0);
        id_req = 1'b0;

        // Reset at beat 3 of 8, then a fresh 8-beat packet
        set_ch(2, 1, 3); req = 4'b0100; val = 4'b0100; id_req = 1'b1;
        tick();
        id_req = 1'b0; ack = 1'b1;
        repeat (3) tick();
        #2;
        rstn_i = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_id", 64'(id), 64'd0);
        check("rst_plsel", 64'(plsel), 64'd0);
        check("rst_val", 64'(a2f_val), 64'd0);
        check("rst_data", 64'(a2f_data), 64'd0);
        check("rst_ack", 64'(ack_o), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        id_req = 1'b1;
        tick();
        id_req = 1'b0;
        repeat (7) tick();
        check("rst_restart_b7", 64'(busy), 64'd1);
        tick();
        check("rst_restart_end", 64'(busy), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < NCH; k++) set_ch(k, $urandom_range(0, 3), $urandom_range(0, 3));
            end
            req    = NCH'($urandom);
            val    = NCH'($urandom);
            id_req = $urandom_range(0, 1) == 1;
            ack    = $urandom_range(0, 3) != 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
